// File: rtl/clken_gen_pkg.sv
// -----------------------------------------------------------------------------
// clkgen_pkg
// Shared types and constants for the clock-enable generator:
//   - state_e    : top-level sequencing states (SETTLE, RUN, APPLY)
//   - chcfg_t    : per-channel configuration record {div, phase, high}
//   - CFG_W      : width of every configuration field
//   - CH_IDX_W   : width of the channel-select field on the config port
//   - LOCK_W     : width of the settle counter
//   - clamp_phase: limits a requested phase to the last slot of the period
// -----------------------------------------------------------------------------
package clkgen_pkg;

    localparam int CFG_W    = 16;
    localparam int CH_IDX_W = 4;
    localparam int LOCK_W   = 32;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_RUN    = 2'd1,
        ST_APPLY  = 2'd2
    } state_e;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] phase;
        logic [CFG_W-1:0] high;
    } chcfg_t;

    // A phase past the end of the period lands on the last slot, so every
    // enabled channel still produces exactly one enable per period.
    function automatic logic [CFG_W-1:0] clamp_phase(input logic [CFG_W-1:0] div,
                                                     input logic [CFG_W-1:0] phase);
        logic [CFG_W-1:0] result;
        result = phase;
        if (div == '0) begin
            result = '0;
        end else if (phase > (div - CFG_W'(1))) begin
            result = div - CFG_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/clken_gen_channel.sv
// -----------------------------------------------------------------------------
// clken_channel
// One output channel: holds its active configuration, a wrap counter that
// runs 0..div-1, and the registered enable / square-wave outputs.
// Ports:
//   clk_i      : fabric clock
//   rst_i      : synchronous active-high reset (clears config and outputs)
//   apply_i    : load cfg_i as the new active configuration this cycle
//   run_i      : outputs are live next cycle; when low, outputs go to 0
//   restart_i  : next cycle is epoch cycle k=0 (counter restarts at 0)
//   cfg_i      : configuration presented for loading
//   clken_o    : one-cycle pulse when the period position equals the phase
//   clkout_o   : high for 'high' cycles starting at the phase slot
// -----------------------------------------------------------------------------
module clken_channel
    import clkgen_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   apply_i,
    input  logic   run_i,
    input  logic   restart_i,
    input  chcfg_t cfg_i,
    output logic   clken_o,
    output logic   clkout_o
);

    logic             en_q,     en_d;
    logic [CFG_W-1:0] div_q,    div_d;
    logic [CFG_W-1:0] dm1_q,    dm1_d;
    logic [CFG_W-1:0] ph_q,     ph_d;
    logic [CFG_W-1:0] high_q,   high_d;
    logic [CFG_W-1:0] cnt_q,    cnt_d;
    logic             clken_q,  clken_d;
    logic             clkout_q, clkout_d;
    logic [CFG_W-1:0] knext;
    logic [CFG_W-1:0] pos;

    // The wrap limit and clamped phase are derived once at load time so the
    // per-cycle path is only an increment, equality and a magnitude compare.
    always_comb begin
        en_d   = en_q;
        div_d  = div_q;
        dm1_d  = dm1_q;
        ph_d   = ph_q;
        high_d = high_q;
        if (apply_i) begin
            en_d   = (cfg_i.div != '0);
            div_d  = cfg_i.div;
            dm1_d  = (cfg_i.div != '0) ? (cfg_i.div - CFG_W'(1)) : '0;
            ph_d   = clamp_phase(cfg_i.div, cfg_i.phase);
            high_d = cfg_i.high;
        end
    end

    // knext is the period position of the cycle being registered. pos is that
    // position measured from the phase slot, i.e. (knext - phase) mod div,
    // formed with one subtraction since both operands are already below div.
    always_comb begin
        if (restart_i) begin
            knext = '0;
        end else if (cnt_q == dm1_q) begin
            knext = '0;
        end else begin
            knext = cnt_q + CFG_W'(1);
        end

        if (knext >= ph_q) begin
            pos = knext - ph_q;
        end else begin
            pos = div_q - (ph_q - knext);
        end

        cnt_d    = run_i ? knext : '0;
        clken_d  = run_i && en_q && (knext == ph_q);
        clkout_d = run_i && en_q && (pos < high_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q     <= 1'b0;
            div_q    <= '0;
            dm1_q    <= '0;
            ph_q     <= '0;
            high_q   <= '0;
            cnt_q    <= '0;
            clken_q  <= 1'b0;
            clkout_q <= 1'b0;
        end else begin
            en_q     <= en_d;
            div_q    <= div_d;
            dm1_q    <= dm1_d;
            ph_q     <= ph_d;
            high_q   <= high_d;
            cnt_q    <= cnt_d;
            clken_q  <= clken_d;
            clkout_q <= clkout_d;
        end
    end

    assign clken_o  = clken_q;
    assign clkout_o = clkout_q;

endmodule

// File: rtl/clken_gen.sv
// -----------------------------------------------------------------------------
// clken_gen
// Multi-channel programmable clock-enable generator. Config writes land in
// per-channel shadow registers; a committing write copies all shadows into
// the channels and restarts them together after a settle interval.
// Ports:
//   refclk     : fabric clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   cfg_valid  : config write request
//   cfg_ready  : write accepted on cycles where cfg_valid & cfg_ready
//   cfg_ch     : target channel (indices >= NUM_CH are acknowledged, dropped)
//   cfg_div    : period in refclk cycles, 0 disables the channel
//   cfg_phase  : enable slot within the period
//   cfg_high   : clkout high cycles per period
//   cfg_commit : copy shadows to active and resettle after this write
//   clken      : per-channel one-cycle enable pulses
//   clkout     : per-channel registered square waves
//   locked     : channels are running on the current active configuration
// -----------------------------------------------------------------------------
module clken_gen
    import clkgen_pkg::*;
#(
    parameter int NUM_CH      = 5,
    parameter int DIV_W       = CFG_W,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic [DIV_W-1:0]    cfg_phase,
    input  logic [DIV_W-1:0]    cfg_high,
    input  logic                cfg_commit,
    output logic [NUM_CH-1:0]   clken,
    output logic [NUM_CH-1:0]   clkout,
    output logic                locked
);

    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    state_e            state_q, state_d;
    logic [LOCK_W-1:0] settle_cnt_q, settle_cnt_d;
    logic              locked_q, locked_d;
    logic              accept;
    logic              restart;
    logic              apply;
    chcfg_t            wr_cfg;
    chcfg_t            shadow_q [NUM_CH];
    chcfg_t            shadow_d [NUM_CH];

    // locked_q only rises after a full cycle in RUN, so whenever it is high
    // the FSM is in RUN and it can double as the write handshake.
    assign accept    = cfg_valid && locked_q;
    assign cfg_ready = locked_q;
    assign locked    = locked_q;
    assign apply     = (state_q == ST_APPLY);

    always_comb begin
        wr_cfg.div   = cfg_div;
        wr_cfg.phase = cfg_phase;
        wr_cfg.high  = cfg_high;
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            ST_SETTLE: begin
                if (settle_cnt_q == LOCK_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    settle_cnt_d = settle_cnt_q + LOCK_W'(1);
                end
            end
            ST_RUN: begin
                if (accept && cfg_commit) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_d      = ST_SETTLE;
                settle_cnt_d = '0;
            end
            default: begin
                state_d      = ST_SETTLE;
                settle_cnt_d = '0;
            end
        endcase
    end

    // Outputs run on cycles that follow two consecutive RUN cycles. The first
    // such cycle is the epoch, where every channel counter restarts at 0.
    assign locked_d = (state_q == ST_RUN) && (state_d == ST_RUN);
    assign restart  = locked_d && !locked_q;

    // Out-of-range channel indices match no shadow slot and are dropped.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_d[i] = shadow_q[i];
            if (accept && (32'(cfg_ch) == i)) begin
                shadow_d[i] = wr_cfg;
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
            locked_q     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            locked_q     <= locked_d;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clken_channel u_ch (
            .clk_i     (refclk),
            .rst_i     (rst),
            .apply_i   (apply),
            .run_i     (locked_d),
            .restart_i (restart),
            .cfg_i     (shadow_q[g]),
            .clken_o   (clken[g]),
            .clkout_o  (clkout[g])
        );
    end

endmodule

// File: doc/clken_gen.md
Name: clken_gen

Overview:
- Parametrised multi-channel clock-enable generator. It derives NUM_CH programmable-rate enables and slow square waves from one fast fabric clock.
- Sits downstream of the main PLL. Gives peripherals (SPI, UART, timers, video sub-rates) runtime-programmable rate, phase and duty without extra PLL outputs.
- Provides a PLL-style locked indication after any (re)configuration.

Parameters:
- NUM_CH, 5, number of output channels (1..16)
- DIV_W, 16, width of divider, phase and high-time fields
- LOCK_CYCLES, 1024, settle cycles before locked asserts (>=2)

Ports:
- refclk  in  1  fabric clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when valid&ready
- cfg_ch  in  4  target channel index
- cfg_div  in  DIV_W  period in refclk cycles; 0 = channel disabled
- cfg_phase  in  DIV_W  enable offset within period
- cfg_high  in  DIV_W  clkout high cycles per period
- cfg_commit  in  1  copy shadow to active and resettle after this write
- clken  out  NUM_CH  one-cycle enable pulse per channel period
- clkout  out  NUM_CH  registered square wave per channel
- locked  out  1  channels running on current active config

Behaviour:
- Reset (rst=1 sampled at edge):
  - clken=0, clkout=0, locked=0, cfg_ready=0.
  - Shadow and active configs cleared (all channels disabled).
  - FSM goes to SETTLE with the settle counter at 0.
  - rst mid-RUN or mid-SETTLE has the same effect on the next edge.
- FSM states:
  - SETTLE: outputs held 0, locked=0, cfg_ready=0. The counter counts to LOCK_CYCLES-1, then the FSM moves to RUN.
  - RUN: locked=1, cfg_ready=1.
  - APPLY: entered for one cycle on an accepted write with cfg_commit=1. It copies shadow to active, forces outputs 0 and locked=0, then moves to SETTLE.
- Lock timing: locked rises exactly LOCK_CYCLES+1 cycles after SETTLE entry. The first cycle with locked=1 is epoch cycle k=0.
- Config writes:
  - Accepted only in RUN on cycles where cfg_valid=1 and cfg_ready=1. Each accepted write updates the shadow registers of cfg_ch.
  - cfg_ch >= NUM_CH: the write is acknowledged but the data is discarded. If commit=1, it still triggers APPLY.
  - A write without commit leaves active config and outputs untouched; locked stays 1.
- Channel i in RUN, with k = cycles since epoch, d = div_i, p = min(phase_i, d-1), h = high_i:
  - clken_i=1 iff k mod d == p.
  - clkout_i=1 iff (k - p) mod d < h. h=0 gives constant 0; h>=d gives constant 1.
  - d=1: clken constant 1.
  - d=0: both outputs constant 0.
- Timing and implementation rules:
  - Outputs are registered.
  - All channel counters restart together at epoch, so relative phase between channels is deterministic.
  - No divide or modulo hardware: each channel uses a wrap counter 0..d-1 plus equality and compare logic.
- Counter width: DIV_W. Wrap compares against d-1 computed once at APPLY.

Decomposition:
- Package clkgen_pkg:
  - FSM state enum (SETTLE, RUN, APPLY).
  - Config record typedef {div, phase, high} at DIV_W.
  - Localparams CH_IDX_W and LOCK_W.
- Sub-module clken_channel, one instance per channel:
  - Holds active config, wrap counter and registered clken/clkout.
  - Inputs: run, restart, cfg.
- Top level holds the FSM, shadow registers and write decode.

Test Plan (LOCK_CYCLES=8, NUM_CH=5, DIV_W=16):
- Reset release, no writes -> locked low 9 cycles after SETTLE entry then high; clken=0, clkout=0 throughout; cfg_ready high with locked.
- Write ch0 div=4 phase=0 high=2 commit=1 -> locked drops next cycle, returns after 9 cycles; from epoch clken[0]=1000 repeating, clkout[0]=1100 repeating.
- Write ch1 div=4 phase=1 high=1 (no commit), then ch3 div=8 phase=3 high=4 commit=1 -> no output change or locked drop after first write; after epoch clken[1]=0100, clkout[1]=0100, clken[3] pulses at k=3,11,19, clkout[3]=00011110.
- Edge cases in one commit:
  - ch2 div=1 high=1 -> clken[2] and clkout[2] constant 1.
  - ch4 div=4 phase=5 high=0 -> clken[4] at k=3,7; clkout[4] constant 0.
  - cfg_ch=9 -> accepted, no effect.
- cfg_valid held high during SETTLE -> cfg_ready=0, no accept until RUN; the write is accepted on the first locked cycle.
- Assert rst for 1 cycle during RUN with all channels toggling -> next cycle all outputs 0 and locked=0; after settle all channels stay disabled (config cleared).
